instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream stage of the 16-bit multicycle processor core. It fetches the instruction word addressed by the core's PC from instruction memory over a req/ack handshake.
- Holds the fetched word in the instruction register (IR) and drives it onto the core's 16-bit instruction input.
- Handles variable memory latency, flush on PC redirect, and memory timeout.

Parameters:
- ADDR_W, 16, instruction memory word-address width; low ADDR_W bits of pc are used.
- TIMEOUT, 15, max BUSY cycles without mem_ack before a fetch is aborted as an error; legal range 1..255.
- NOP_WORD, 16'h0000, value loaded into IR on reset and on timeout.

Ports:
- CLOCK_50  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  16  word address of the instruction to fetch; sampled only on an accepted fetch_start.
- fetch_start  in  1  one-cycle request from control (IR-write phase) to fetch at pc.
- flush  in  1  abort the in-flight fetch (PC redirect by branch/jump).
- instruction  out  16  IR contents; feeds the core's opcode/register fields.
- fetch_done  out  1  one-cycle pulse; IR updated this cycle.
- fetch_err  out  1  one-cycle pulse, coincident with fetch_done, on timeout.
- busy  out  1  high while a fetch is outstanding.
- mem_addr  out  ADDR_W  read address to instruction memory; registered.
- mem_rd  out  1  read request; registered, level held until ack/abort.
- mem_ack  in  1  memory has valid mem_rdata this cycle; meaningful only while mem_rd=1.
- mem_rdata  in  16  instruction word from memory.
- fetch_count  out  16  number of successfully completed fetches; wraps 16'hFFFF->0.

Behaviour:
- Reset (sync, active-high; valid in any state, including mid-fetch):
  - instruction=NOP_WORD, mem_rd=0, mem_addr=0, fetch_done=0, fetch_err=0, busy=0, fetch_count=0.
  - Timeout counter cleared, state=IDLE.
  - A mem_ack in the reset cycle is ignored.
- States: IDLE, BUSY.
- IDLE:
  - fetch_start=1 (and flush=0): addr_q<=pc[ADDR_W-1:0], mem_addr<=same, mem_rd<=1, busy<=1, timeout counter<=0, go BUSY.
  - fetch_start with flush=1 in the same IDLE cycle: request dropped, stay IDLE.
- BUSY, evaluated each cycle in priority order:
  1. flush=1: mem_rd<=0, busy<=0, IR unchanged, no fetch_done, go IDLE. Flush beats a coincident mem_ack, whose data is discarded.
  2. mem_ack=1: IR<=mem_rdata, fetch_done<=1 next cycle, fetch_count+1, mem_rd<=0, busy<=0, go IDLE.
  3. Counter==TIMEOUT-1: IR<=NOP_WORD, fetch_done<=1 and fetch_err<=1 next cycle, fetch_count unchanged, mem_rd<=0, busy<=0, go IDLE.
  4. Otherwise: counter+1; mem_rd and mem_addr held stable.
  - fetch_start in BUSY is ignored; pc changes in BUSY do not affect mem_addr.
- Latency:
  - fetch_start at edge N puts mem_rd=1 in cycle N+1.
  - mem_ack sampled at edge N+k puts instruction/fetch_done valid in cycle N+k+1.
  - Minimum 2 cycles start-to-done, with ack in the first mem_rd cycle.
  - Back-to-back: fetch_start in the fetch_done cycle is accepted (state already IDLE).
- Timeout example: with TIMEOUT=T, abort happens after T consecutive mem_rd cycles without ack.
- IR holds its value indefinitely between fetches; instruction is never X after reset.
- fetch_done and fetch_err are never high for more than one consecutive cycle per fetch.

Decomposition:
- Shared package proc_pkg:
  - WORD_W=16, OPCODE_W=4, NOP_WORD default.
  - Fetch-state enum (IDLE, BUSY).
  - Opcode field positions [15:12], [11:8], [7:4], [3:0], shared with control and register file.
- One natural sub-module: fetch_timeout_ctr (load/clear, increment, terminal-count flag; parameter TIMEOUT).
- FSM, IR and fetch_count stay in instr_fetch_unit.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> instruction=16'h0000, mem_rd=0, busy=0, fetch_count=0.
- Basic fetch: pc=16'h0005, fetch_start pulse, memory acks with 16'h1234 in the first mem_rd cycle:
  - mem_addr=5 and mem_rd=1 for exactly 1 cycle.
  - instruction=16'h1234 and fetch_done=1 two cycles after start.
  - fetch_count=1.
- Wait states: ack delayed 4 cycles, pc changed to 16'h0009 during BUSY:
  - mem_addr stays 5, mem_rd high 5 cycles.
  - fetch_start in BUSY ignored.
  - IR loads data once.
- Flush vs ack: flush and mem_ack (data 16'hBEEF) in the same BUSY cycle:
  - IR unchanged, no fetch_done, mem_rd=0 next cycle, fetch_count unchanged.
- Timeout: TIMEOUT=3, no ack:
  - mem_rd high 3 cycles, then instruction=NOP_WORD with fetch_done=1 and fetch_err=1 for one cycle.
  - fetch_count unchanged.
- Reset mid-fetch and back-to-back: reset asserted during BUSY -> next cycle mem_rd=0, state IDLE. Then two fetches with fetch_start in each fetch_done cycle -> both complete, fetch_count=2; a preloaded count of 16'hFFFF wraps to 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit multicycle core: word sizes,
// the fetch-state encoding and instruction field positions.
package proc_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned OPCODE_W = 4;

  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fetchState_t;

  // Instruction field positions, shared with control and the register file
  localparam int unsigned OPCODE_HI = 15;
  localparam int unsigned OPCODE_LO = 12;
  localparam int unsigned RA_HI     = 11;
  localparam int unsigned RA_LO     = 8;
  localparam int unsigned RB_HI     = 7;
  localparam int unsigned RB_LO     = 4;
  localparam int unsigned RC_HI     = 3;
  localparam int unsigned RC_LO     = 0;

  function automatic logic [OPCODE_W-1:0] opcodeOf(input logic [WORD_W-1:0] word);
    return word[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Cycle counter for an outstanding fetch: cleared when a fetch is
// launched, counts while waiting, flags the last permitted wait cycle.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  logic [7:0] count;

  // Clear has priority so a new fetch always starts from zero
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

  // Terminal on the TIMEOUT-th waiting cycle (count starts at 0)
  always_comb begin
    terminal = (count == 8'(TIMEOUT - 1));
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues a req/ack read at pc, loads the returned
// word into IR, and handles flush on redirect and memory timeout.
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       TIMEOUT  = 15,
  parameter logic [WORD_W-1:0] NOP_WORD = proc_pkg::NOP_WORD
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [15:0]       pc,
  input  logic              fetch_start,
  input  logic              flush,
  output logic [15:0]       instruction,
  output logic              fetch_done,
  output logic              fetch_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       fetch_count
);

  fetchState_t       state;
  fetchState_t       nextState;
  logic              acceptStart;
  logic              takeAck;
  logic              abortTimeout;
  logic              timeoutTerminal;
  logic [15:0]       irQ;
  logic [ADDR_W-1:0] addrQ;
  logic              doneQ;
  logic              errQ;
  logic [15:0]       fetchCountQ;

  fetch_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) uTimeout (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clear   (acceptStart),
    .inc     (state == BUSY),
    .terminal(timeoutTerminal)
  );

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; in BUSY, flush beats ack, and ack beats timeout
  always_comb begin
    nextState    = state;
    acceptStart  = 1'b0;
    takeAck      = 1'b0;
    abortTimeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetch_start && !flush) begin
          acceptStart = 1'b1;
          nextState   = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          nextState = IDLE;
        end else if (mem_ack) begin
          takeAck   = 1'b1;
          nextState = IDLE;
        end else if (timeoutTerminal) begin
          abortTimeout = 1'b1;
          nextState    = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Outputs decoded from registered state and datapath registers only
  always_comb begin
    busy        = (state == BUSY);
    mem_rd      = (state == BUSY);
    mem_addr    = addrQ;
    instruction = irQ;
    fetch_done  = doneQ;
    fetch_err   = errQ;
    fetch_count = fetchCountQ;
  end

  // IR, address latch, completion pulses and completed-fetch counter
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      irQ         <= NOP_WORD;
      addrQ       <= '0;
      doneQ       <= 1'b0;
      errQ        <= 1'b0;
      fetchCountQ <= '0;
    end else begin
      doneQ <= takeAck || abortTimeout;
      errQ  <= abortTimeout;
      if (acceptStart) begin
        addrQ <= pc[ADDR_W-1:0];
      end
      if (takeAck) begin
        irQ         <= mem_rdata;
        fetchCountQ <= fetchCountQ + 16'd1;
      end else if (abortTimeout) begin
        irQ <= NOP_WORD;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one default instance (TIMEOUT=15)
// and one with TIMEOUT=3 for the abort path.
module tb_instr_fetch_unit;

  logic        CLOCK_50 = 1'b0;
  logic        reset, fetch_start, flush, mem_ack;
  logic [15:0] pc, mem_rdata;
  logic [15:0] instruction, fetch_count;
  logic        fetch_done, fetch_err, busy, mem_rd;
  logic [15:0] mem_addr;

  logic        tReset, tStart, tFlush, tAck;
  logic [15:0] tPc, tRdata;
  logic [15:0] tInstr, tCount;
  logic        tDone, tErr, tBusy, tRd;
  logic [15:0] tAddr;

  int nVec = 0;
  int nMis = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  instr_fetch_unit #(.ADDR_W(16), .TIMEOUT(15)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pc(pc), .fetch_start(fetch_start),
    .flush(flush), .instruction(instruction), .fetch_done(fetch_done),
    .fetch_err(fetch_err), .busy(busy), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.ADDR_W(16), .TIMEOUT(3)) dutT3 (
    .CLOCK_50(CLOCK_50), .reset(tReset), .pc(tPc), .fetch_start(tStart),
    .flush(tFlush), .instruction(tInstr), .fetch_done(tDone),
    .fetch_err(tErr), .busy(tBusy), .mem_addr(tAddr), .mem_rd(tRd),
    .mem_ack(tAck), .mem_rdata(tRdata), .fetch_count(tCount)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tReset = 1'b1;
    tick(); tick();
    reset = 1'b0; tReset = 1'b0;
    nVec++; if (instruction !== 16'h0000) begin nMis++; $display("FAIL reset_instr got %h exp %h", instruction, 16'h0000); end
    nVec++; if (mem_rd !== 1'b0) begin nMis++; $display("FAIL reset_mem_rd got %b exp 0", mem_rd); end
    nVec++; if (busy !== 1'b0) begin nMis++; $display("FAIL reset_busy got %b exp 0", busy); end
    nVec++; if (fetch_count !== 16'd0) begin nMis++; $display("FAIL reset_count got %h exp 0000", fetch_count); end
    nVec++; if (fetch_done !== 1'b0) begin nMis++; $display("FAIL reset_done got %b exp 0", fetch_done); end
    nVec++; if (mem_addr !== 16'd0) begin nMis++; $display("FAIL reset_addr got %h exp 0000", mem_addr); end
  endtask

  task automatic test_basic_fetch();
    pc = 16'h0005; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    nVec++; if (mem_rd !== 1'b1) begin nMis++; $display("FAIL basic_rd_on got %b exp 1", mem_rd); end
    nVec++; if (mem_addr !== 16'h0005) begin nMis++; $display("FAIL basic_addr got %h exp 0005", mem_addr); end
    nVec++; if (busy !== 1'b1) begin nMis++; $display("FAIL basic_busy got %b exp 1", busy); end
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0;
    nVec++; if (mem_rd !== 1'b0) begin nMis++; $display("FAIL basic_rd_off got %b exp 0", mem_rd); end
    nVec++; if (instruction !== 16'h1234) begin nMis++; $display("FAIL basic_instr got %h exp 1234", instruction); end
    nVec++; if (fetch_done !== 1'b1) begin nMis++; $display("FAIL basic_done got %b exp 1", fetch_done); end
    nVec++; if (fetch_err !== 1'b0) begin nMis++; $display("FAIL basic_err got %b exp 0", fetch_err); end
    nVec++; if (fetch_count !== 16'd1) begin nMis++; $display("FAIL basic_count got %h exp 0001", fetch_count); end
    tick();
    nVec++; if (fetch_done !== 1'b0) begin nMis++; $display("FAIL basic_done_pulse got %b exp 0", fetch_done); end
  endtask

  task automatic test_wait_states();
    pc = 16'h0005; fetch_start = 1'b1;
    tick();
    pc = 16'h0009;
    for (int i = 0; i < 5; i++) begin
      nVec++; if (mem_rd !== 1'b1) begin nMis++; $display("FAIL wait_rd[%0d] got %b exp 1", i, mem_rd); end
      nVec++; if (mem_addr !== 16'h0005) begin nMis++; $display("FAIL wait_addr[%0d] got %h exp 0005", i, mem_addr); end
      nVec++; if (fetch_done !== 1'b0) begin nMis++; $display("FAIL wait_done[%0d] got %b exp 0", i, fetch_done); end
      if (i == 4) begin mem_ack = 1'b1; mem_rdata = 16'hABCD; end
      tick();
    end
    mem_ack = 1'b0; fetch_start = 1'b0;
    nVec++; if (instruction !== 16'hABCD) begin nMis++; $display("FAIL wait_instr got %h exp abcd", instruction); end
    nVec++; if (fetch_done !== 1'b1) begin nMis++; $display("FAIL wait_done got %b exp 1", fetch_done); end
    nVec++; if (mem_rd !== 1'b0) begin nMis++; $display("FAIL wait_rd_off got %b exp 0", mem_rd); end
    nVec++; if (fetch_count !== 16'd2) begin nMis++; $display("FAIL wait_count got %h exp 0002", fetch_count); end
    tick();
    nVec++; if (mem_rd !== 1'b0) begin nMis++; $display("FAIL wait_no_restart got %b exp 0", mem_rd); end
    nVec++; if (fetch_count !== 16'd2) begin nMis++; $display("FAIL wait_count_hold got %h exp 0002", fetch_count); end
  endtask

  task automatic test_flush_vs_ack();
    pc = 16'h0007; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    nVec++; if (mem_rd !== 1'b1) begin nMis++; $display("FAIL flush_rd_on got %b exp 1", mem_rd); end
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    flush = 1'b0; mem_ack = 1'b0;
    nVec++; if (mem_rd !== 1'b0) begin nMis++; $display("FAIL flush_rd_off got %b exp 0", mem_rd); end
    nVec++; if (busy !== 1'b0) begin nMis++; $display("FAIL flush_busy got %b exp 0", busy); end
    nVec++; if (instruction !== 16'hABCD) begin nMis++; $display("FAIL flush_instr got %h exp abcd", instruction); end
    nVec++; if (fetch_done !== 1'b0) begin nMis++; $display("FAIL flush_done got %b exp 0", fetch_done); end
    nVec++; if (fetch_count !== 16'd2) begin nMis++; $display("FAIL flush_count got %h exp 0002", fetch_count); end
    // start and flush together in IDLE: request dropped
    pc = 16'h0020; fetch_start = 1'b1; flush = 1'b1;
    tick();
    fetch_start = 1'b0; flush = 1'b0;
    nVec++; if (mem_rd !== 1'b0) begin nMis++; $display("FAIL flush_idle_drop got %b exp 0", mem_rd); end
  endtask

  task automatic test_timeout();
    tPc = 16'h0040; tStart = 1'b1;
    tick();
    tStart = 1'b0; tAck = 1'b1; tRdata = 16'h5A5A;
    tick();
    tAck = 1'b0;
    nVec++; if (tInstr !== 16'h5A5A) begin nMis++; $display("FAIL to_pre_instr got %h exp 5a5a", tInstr); end
    tPc = 16'h0041; tStart = 1'b1;
    tick();
    tStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nVec++; if (tRd !== 1'b1) begin nMis++; $display("FAIL to_rd[%0d] got %b exp 1", i, tRd); end
      nVec++; if (tDone !== 1'b0) begin nMis++; $display("FAIL to_done_early[%0d] got %b exp 0", i, tDone); end
      tick();
    end
    nVec++; if (tRd !== 1'b0) begin nMis++; $display("FAIL to_rd_off got %b exp 0", tRd); end
    nVec++; if (tInstr !== 16'h0000) begin nMis++; $display("FAIL to_instr got %h exp 0000", tInstr); end
    nVec++; if (tDone !== 1'b1) begin nMis++; $display("FAIL to_done got %b exp 1", tDone); end
    nVec++; if (tErr !== 1'b1) begin nMis++; $display("FAIL to_err got %b exp 1", tErr); end
    nVec++; if (tCount !== 16'd1) begin nMis++; $display("FAIL to_count got %h exp 0001", tCount); end
    tick();
    nVec++; if (tDone !== 1'b0) begin nMis++; $display("FAIL to_done_pulse got %b exp 0", tDone); end
    nVec++; if (tErr !== 1'b0) begin nMis++; $display("FAIL to_err_pulse got %b exp 0", tErr); end
  endtask

  task automatic test_reset_midfetch();
    pc = 16'h0003; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    nVec++; if (mem_rd !== 1'b1) begin nMis++; $display("FAIL rmid_rd_on got %b exp 1", mem_rd); end
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    reset = 1'b0; mem_ack = 1'b0;
    nVec++; if (mem_rd !== 1'b0) begin nMis++; $display("FAIL rmid_rd got %b exp 0", mem_rd); end
    nVec++; if (busy !== 1'b0) begin nMis++; $display("FAIL rmid_busy got %b exp 0", busy); end
    nVec++; if (instruction !== 16'h0000) begin nMis++; $display("FAIL rmid_instr got %h exp 0000", instruction); end
    nVec++; if (fetch_done !== 1'b0) begin nMis++; $display("FAIL rmid_done got %b exp 0", fetch_done); end
    nVec++; if (fetch_count !== 16'd0) begin nMis++; $display("FAIL rmid_count got %h exp 0000", fetch_count); end
  endtask

  task automatic test_back_to_back();
    pc = 16'h0010; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    nVec++; if (instruction !== 16'h1111 || fetch_done !== 1'b1) begin nMis++; $display("FAIL b2b_first got %h/%b exp 1111/1", instruction, fetch_done); end
    pc = 16'h0011; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    nVec++; if (mem_rd !== 1'b1) begin nMis++; $display("FAIL b2b_rd got %b exp 1", mem_rd); end
    nVec++; if (mem_addr !== 16'h0011) begin nMis++; $display("FAIL b2b_addr got %h exp 0011", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_ack = 1'b0;
    nVec++; if (instruction !== 16'h2222 || fetch_done !== 1'b1) begin nMis++; $display("FAIL b2b_second got %h/%b exp 2222/1", instruction, fetch_done); end
    nVec++; if (fetch_count !== 16'd2) begin nMis++; $display("FAIL b2b_count got %h exp 0002", fetch_count); end
  endtask

  task automatic test_count_wrap();
    force dut.fetchCountQ = 16'hFFFF;
    tick();
    release dut.fetchCountQ;
    nVec++; if (fetch_count !== 16'hFFFF) begin nMis++; $display("FAIL wrap_preload got %h exp ffff", fetch_count); end
    pc = 16'h0030; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h3333;
    tick();
    mem_ack = 1'b0;
    nVec++; if (fetch_count !== 16'h0000) begin nMis++; $display("FAIL wrap_count got %h exp 0000", fetch_count); end
    nVec++; if (instruction !== 16'h3333) begin nMis++; $display("FAIL wrap_instr got %h exp 3333", instruction); end
  endtask

  initial begin
    reset = 1'b0; fetch_start = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    pc = '0; mem_rdata = '0;
    tReset = 1'b0; tStart = 1'b0; tFlush = 1'b0; tAck = 1'b0;
    tPc = '0; tRdata = '0;
    #1;
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_flush_vs_ack();
    test_timeout();
    test_reset_midfetch();
    test_back_to_back();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "bench did not complete");
  end

endmodule
